// File: rtl/sobel_window.sv
// 3x3 neighbourhood generator for a raster pixel stream, feeding the Sobel convolution stage.
// Optional short-frame checker: define SOBEL_WINDOW_FRAME_CHK_EN to build frame_err_o logic.
module sobel_window #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int DATA_WD = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pix_valid_i,
    input  logic [DATA_WD-1:0] pix_i,
    input  logic               sof_i,
    output logic [DATA_WD-1:0] i_0,
    output logic [DATA_WD-1:0] i_1,
    output logic [DATA_WD-1:0] i_2,
    output logic [DATA_WD-1:0] i_3,
    output logic [DATA_WD-1:0] i_4,
    output logic [DATA_WD-1:0] i_5,
    output logic [DATA_WD-1:0] i_6,
    output logic [DATA_WD-1:0] i_7,
    output logic [DATA_WD-1:0] i_8,
    output logic               dl_sobel_en,
    output logic               frame_done_o,
    output logic               frame_err_o
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]      col, pos_col;
    logic [RW-1:0]      row, pos_row;
    logic [DATA_WD-1:0] lb1 [IMG_W];
    logic [DATA_WD-1:0] lb2 [IMG_W];
    logic [DATA_WD-1:0] lb_top, lb_mid;
    logic [DATA_WD-1:0] win [9];

    // A start-of-frame pixel overrides whatever the counters say.
    always_comb begin
        pos_col = sof_i ? '0 : col;
        pos_row = sof_i ? '0 : row;
    end

    assign lb_top = lb2[pos_col];
    assign lb_mid = lb1[pos_col];

    // Line storage carries no reset; rows 0/1 never emit, so stale data is never visible.
    always_ff @(posedge clk_i) begin
        if (pix_valid_i) begin
            lb2[pos_col] <= lb_mid;
            lb1[pos_col] <= pix_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid_i) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col <= pos_col + CW'(1);
                row <= pos_row;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 9; k++) win[k] <= '0;
            dl_sobel_en  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            dl_sobel_en  <= pix_valid_i && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
            frame_done_o <= pix_valid_i && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            if (pix_valid_i) begin
                win[0] <= win[1]; win[1] <= win[2]; win[2] <= lb_top;
                win[3] <= win[4]; win[4] <= win[5]; win[5] <= lb_mid;
                win[6] <= win[7]; win[7] <= win[8]; win[8] <= pix_i;
            end
        end
    end

    assign i_0 = win[0];
    assign i_1 = win[1];
    assign i_2 = win[2];
    assign i_3 = win[3];
    assign i_4 = win[4];
    assign i_5 = win[5];
    assign i_6 = win[6];
    assign i_7 = win[7];
    assign i_8 = win[8];

`ifdef SOBEL_WINDOW_FRAME_CHK_EN
    // Sticky: a sof pixel arriving anywhere but (0,0) means the previous frame was short.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            frame_err_o <= 1'b0;
        else if (pix_valid_i && sof_i && ((col != '0) || (row != '0)))
            frame_err_o <= 1'b1;
    end
`else
    assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window.sv
// Randomized bench for sobel_window on an 8x6 frame, checked against an image-array model.
module tb_sobel_window;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, pv, sof;
    logic [DW-1:0] pix;
    logic [DW-1:0] i_0, i_1, i_2, i_3, i_4, i_5, i_6, i_7, i_8;
    logic          en, done, err;

    always #5 clk = ~clk;

    sobel_window #(.IMG_W(W), .IMG_H(H), .DATA_WD(DW)) dut (
        .clk_i(clk), .rst_i(rst), .pix_valid_i(pv), .pix_i(pix), .sof_i(sof),
        .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3), .i_4(i_4),
        .i_5(i_5), .i_6(i_6), .i_7(i_7), .i_8(i_8),
        .dl_sobel_en(en), .frame_done_o(done), .frame_err_o(err)
    );

    wire [71:0] taps = {i_0, i_1, i_2, i_3, i_4, i_5, i_6, i_7, i_8};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the frame as a 2D image plus the current raster position.
    logic [7:0]  img [H][W];
    int          mr, mc;
    logic        m_err;
    logic [71:0] exp_win, prev_taps;
    logic        exp_en, exp_done;
    int          n_en, n_done;
    logic [7:0]  last_done_i8;
    logic [71:0] seen [$];
    logic [71:0] ramp [$];

    task automatic model_reset();
        mr = 0; mc = 0; m_err = 1'b0; prev_taps = '0;
    endtask

    task automatic step(input bit v, input logic [7:0] p, input bit s);
        int r, c;
        pv = v; pix = p; sof = s;
        @(posedge clk);
        exp_en = 1'b0; exp_done = 1'b0;
        if (v) begin
`ifdef SOBEL_WINDOW_FRAME_CHK_EN
            if (s && (mr != 0 || mc != 0)) m_err = 1'b1;
`endif
            if (s) begin r = 0; c = 0; end
            else begin r = mr; c = mc; end
            img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                exp_en  = 1'b1;
                exp_win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                           img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                           img[r][c-2],   img[r][c-1],   img[r][c]};
                exp_done = (r == H-1) && (c == W-1);
            end
            mr = r; mc = c + 1;
            if (mc == W) begin
                mc = 0; mr = r + 1;
                if (mr == H) mr = 0;
            end
        end
        #1;
        chk("en", en, exp_en);
        chk("done", done, exp_done);
        chk("err", err, m_err);
        if (exp_en) begin
            chk("win", taps, exp_win);
            seen.push_back(taps);
            n_en++;
        end
        if (!v) chk("hold", taps, prev_taps);
        if (done) begin
            n_done++;
            last_done_i8 = i_8;
        end
        prev_taps = taps;
    endtask

    task automatic rnd_pix(input bit s);
        step(1'b1, 8'($urandom_range(0, 255)), s);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pv = 1'b0; sof = 1'b0; pix = '0;
        model_reset();
        n_en = 0; n_done = 0; last_done_i8 = '0;
        #2;
        chk("rst_taps", taps, 72'h0);
        chk("rst_en", en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        #20 rst = 1'b0;

        // Ramp frame
        seen.delete(); n_en = 0; n_done = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                step(1'b1, 8'(r*8 + c), (r == 0 && c == 0));
        chk("ramp_cnt", n_en, 24);
        chk("ramp_done_cnt", n_done, 1);
        chk("ramp_first", seen[0], 72'h000102_08090a_101112);
        chk("ramp_done_i8", last_done_i8, 8'd47);
        ramp = seen;

        // Gapped ramp: idle cycles carry junk pixel/sof that must be ignored
        seen.delete(); n_en = 0; n_done = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(0, 1) == 1)
                    step(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                step(1'b1, 8'(r*8 + c), (r == 0 && c == 0));
            end
        chk("gap_cnt", seen.size(), 24);
        chk("gap_done_cnt", n_done, 1);
        for (int k = 0; k < 24 && k < seen.size(); k++)
            chk("gap_seq", seen[k], ramp[k]);

        // Constant frames back-to-back; the second relies on counter wrap, no sof
        for (int f = 0; f < 2; f++) begin
            seen.delete(); n_en = 0; n_done = 0;
            for (int k = 0; k < W*H; k++) step(1'b1, 8'h80, (f == 0 && k == 0));
            chk("const_cnt", n_en, 24);
            chk("const_done_cnt", n_done, 1);
            chk("const_win", seen[seen.size()-1], {9{8'h80}});
        end

        // Reset mid-frame while a pixel is presented
        for (int k = 0; k < 21; k++) rnd_pix(k == 0);
        pv = 1'b1; pix = 8'h55; sof = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_taps", taps, 72'h0);
        chk("mid_rst_en", en, 1'b0);
        @(posedge clk); #1;
        chk("mid_rst_hold", taps, 72'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen.delete(); n_en = 0; n_done = 0;
        for (int k = 0; k < W*H; k++) rnd_pix(1'b0);
        chk("post_rst_cnt", n_en, 24);
        chk("post_rst_done", n_done, 1);

        // Early sof at (3,5): aborted frame gives no frame_done
        n_done = 0;
        for (int k = 0; k < 3*W + 5; k++) rnd_pix(k == 0);
        chk("abort_done", n_done, 0);
        n_en = 0;
        for (int k = 0; k < W*H; k++) begin
            rnd_pix(k == 0);
            if (k == 2*W + 1) chk("early_no_en", n_en, 0);
        end
        chk("early_cnt", n_en, 24);
        chk("early_done", n_done, 1);
`ifdef SOBEL_WINDOW_FRAME_CHK_EN
        chk("early_err", err, 1'b1);
`else
        chk("early_err", err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sobel_window.md
Name: sobel_window

Overview:
- Upstream neighbour of the Sobel convolution stage.
- Accepts a raster-order 8-bit grayscale pixel stream, buffers the two previous image rows, and emits a registered 3x3 neighbourhood (taps i_0..i_8) with a one-cycle window-valid strobe (dl_sobel_en) that drives the convolution stage directly.
- Emits windows only where all nine taps lie inside the frame.

Parameters:
IMG_W, 640, pixels per row (>=3)
IMG_H, 480, rows per frame (>=3)
DATA_WD, 8, pixel width in bits

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  reset, asynchronous, active-high
pix_valid_i  input  1  pixel qualifier, one pixel accepted per cycle when high
pix_i  input  DATA_WD  pixel value
sof_i  input  1  start of frame; meaningful only with pix_valid_i; marks pixel (row 0, col 0)
i_0..i_8  output  DATA_WD each  window taps, row-major, i_0 top-left, i_4 centre, i_8 bottom-right
dl_sobel_en  output  1  window valid, one-cycle strobe
frame_done_o  output  1  one-cycle pulse with the last window of a frame
frame_err_o  output  1  sticky frame-length error (see Optional Feature)

Behaviour:
- Reset: col/row counters=0, all taps=0, dl_sobel_en=0, frame_done_o=0, frame_err_o=0. Line-buffer storage is not reset; stale contents are never emitted.
- Position counters: col 0..IMG_W-1, row 0..IMG_H-1. Both advance only on accepted pixels (pix_valid_i=1).
  - col wraps to 0 and increments row.
  - After (IMG_H-1, IMG_W-1), both wrap to 0.
  - An accepted pixel with sof_i=1 is treated as (0,0) regardless of counter state; the next position is (0,1).
- Line buffers: two buffers, IMG_W deep, DATA_WD wide. For an accepted pixel at col c:
  - Read lb1[c] (row r-1) and lb2[c] (row r-2), read-before-write.
  - Write lb2[c] <= lb1[c] and lb1[c] <= pix_i.
  - Inference as synchronous RAM is allowed, provided the externally visible timing below is preserved.
- Window shift on each accepted pixel:
  - {i_0,i_3,i_6} <= {i_1,i_4,i_7}
  - {i_1,i_4,i_7} <= {i_2,i_5,i_8}
  - {i_2,i_5,i_8} <= {lb2[c], lb1[c], pix_i}
  - Taps hold when pix_valid_i=0.
- Window validity and latency:
  - dl_sobel_en=1 in the cycle after an accepted pixel with row>=2 and col>=2; 0 otherwise, including every cycle with no accepted pixel.
  - The window is centred on (row-1, col-1).
  - Taps are stable while dl_sobel_en=1.
- Boundaries:
  - Columns 0/1 of each row leave windows mixing old-row columns; dl_sobel_en is suppressed there.
  - Rows 0/1 produce no windows.
  - Windows per frame: (IMG_W-2)*(IMG_H-2) = 304964 at default parameters.
- frame_done_o: high in the same cycle as the dl_sobel_en of the pixel at (IMG_H-1, IMG_W-1).
- Back-to-back frames need no idle cycles. Because rows 0/1 are suppressed, no emitted window spans two frames.
- sof_i mid-frame: counters restart at (0,1) after that pixel; the partial frame is abandoned with no frame_done_o.
- Reset mid-frame: immediate return to reset state; the next accepted pixel is (0,0) even without sof_i.

Optional Feature:
Macro SOBEL_WINDOW_FRAME_CHK_EN.
- Defined: frame_err_o is set when an accepted sof_i pixel arrives while the counters are not at (0,0), i.e. a short frame. It stays set until rst_i.
- Undefined: frame_err_o is tied to 0 and no checker logic is built.
- The port list is identical in both cases.

Test Plan:
- Reset: assert rst_i mid-frame with pix_valid_i=1 -> all taps=0, dl_sobel_en=0 asynchronously. After release, the first pixel is treated as (0,0) without sof_i.
- Ramp frame: IMG_W=8, IMG_H=6, pix=row*8+col, continuous valid, sof_i on the first pixel.
  - First dl_sobel_en one cycle after pixel (2,2), with i_0..i_8 = 0,1,2,8,9,10,16,17,18.
  - Exactly 24 strobes.
  - frame_done_o coincides with the window i_8=47.
- Gapped stream: same ramp with pix_valid_i randomly low 50% -> identical window sequence to the ramp test, no strobe in idle cycles.
- Full default frame, constant pix 0x80 -> 304964 strobes, all taps 0x80, one frame_done_o; then a back-to-back second frame gives the identical count.
- Early sof: sof_i at position (3,5) of an 8x6 frame -> no strobes until new-frame pixel (2,2), no frame_done_o for the aborted frame. frame_err_o=1 with SOBEL_WINDOW_FRAME_CHK_EN, 0 without.
